// File: rtl/bmu_issue_arbiter_pkg.sv
// -----------------------------------------------------------------------------
// bmu_pkg
// Shared types for the BMU issue arbiter:
//   bmu_ap_t    - packed BMU opcode bundle (21 bits, csr_write is the MSB)
//   arb_state_e - arbiter quiesce FSM states
//   BMU_W       - default operand/result width
// -----------------------------------------------------------------------------
package bmu_pkg;

   localparam int BMU_W = 32;

   typedef struct packed {
      logic csr_write;
      logic csr_imm;
      logic zbb;
      logic zba;
      logic land;
      logic lxor;
      logic sll;
      logic sra;
      logic rol;
      logic bext;
      logic sh3add;
      logic add;
      logic slt;
      logic unsign;
      logic sub;
      logic clz;
      logic cpop;
      logic siext_h;
      logic min;
      logic packu;
      logic gorc;
   } bmu_ap_t;

   typedef enum logic [1:0] {
      RUN   = 2'd0,
      DRAIN = 2'd1,
      HALT  = 2'd2
   } arb_state_e;

endpackage

// File: rtl/bmu_issue_arbiter_if.sv
// -----------------------------------------------------------------------------
// bmu_issue_arbiter_if
// Bundles requester ports, the BMU issue/result bundle, the response port,
// the quiesce handshake and the FSM debug view.
//   master : the arbiter (drives req_ready, bmu_*_in, rsp_*, quiesce_ack,
//            busy, dbg_state)
//   slave  : requesters, BMU and control environment
//
// Handshake: a request transfers in any cycle where req_valid[i] and
// req_ready[i] are both high at the rising edge. req_valid must not depend
// on req_ready; once raised it is held until the transfer. req_ready is at
// most one-hot. rsp_valid is a single-cycle strobe with no backpressure.
// -----------------------------------------------------------------------------
interface bmu_issue_arbiter_if #(
   parameter int NREQ = 2,
   parameter int W    = bmu_pkg::BMU_W
);
   import bmu_pkg::*;

   localparam int IDW = $clog2(NREQ);

   logic [NREQ-1:0]         req_valid;
   logic [NREQ-1:0]         req_ready;
   logic [NREQ-1:0][W-1:0]  req_a;
   logic [NREQ-1:0][W-1:0]  req_b;
   bmu_ap_t [NREQ-1:0]      req_ap;
   logic [NREQ-1:0]         req_csr_ren;
   logic [NREQ-1:0][W-1:0]  req_csr_rddata;

   logic                    bmu_valid_in;
   logic [W-1:0]            bmu_a_in;
   logic [W-1:0]            bmu_b_in;
   bmu_ap_t                 bmu_ap;
   logic                    bmu_csr_ren_in;
   logic [W-1:0]            bmu_csr_rddata_in;
   logic [W-1:0]            bmu_result_ff;
   logic                    bmu_error;

   logic                    rsp_valid;
   logic [IDW-1:0]          rsp_id;
   logic [W-1:0]            rsp_data;
   logic                    rsp_error;

   logic                    quiesce_req;
   logic                    quiesce_ack;
   logic                    busy;
   arb_state_e              dbg_state;

   modport master (
      input  req_valid, req_a, req_b, req_ap, req_csr_ren, req_csr_rddata,
      input  bmu_result_ff, bmu_error, quiesce_req,
      output req_ready,
      output bmu_valid_in, bmu_a_in, bmu_b_in, bmu_ap, bmu_csr_ren_in, bmu_csr_rddata_in,
      output rsp_valid, rsp_id, rsp_data, rsp_error,
      output quiesce_ack, busy, dbg_state
   );

   modport slave (
      output req_valid, req_a, req_b, req_ap, req_csr_ren, req_csr_rddata,
      output bmu_result_ff, bmu_error, quiesce_req,
      input  req_ready,
      input  bmu_valid_in, bmu_a_in, bmu_b_in, bmu_ap, bmu_csr_ren_in, bmu_csr_rddata_in,
      input  rsp_valid, rsp_id, rsp_data, rsp_error,
      input  quiesce_ack, busy, dbg_state
   );

endinterface

// File: rtl/bmu_rr_arbiter.sv
// -----------------------------------------------------------------------------
// bmu_rr_arbiter
// Combinational round-robin pick. The search starts at i_last+1 (mod NREQ)
// and wraps, so the previous winner has the lowest priority.
//   i_req  - request vector
//   i_last - index of the previous winner
//   o_gnt  - one-hot grant (zero when no request)
//   o_idx  - index of the granted requester (0 when no request)
// -----------------------------------------------------------------------------
module bmu_rr_arbiter #(
   parameter int NREQ = 2,
   localparam int IDW = $clog2(NREQ)
) (
   input  logic [NREQ-1:0] i_req,
   input  logic [IDW-1:0]  i_last,
   output logic [NREQ-1:0] o_gnt,
   output logic [IDW-1:0]  o_idx
);

   // Walk from the farthest candidate to the nearest; the last match
   // written is the nearest one after i_last, which is the winner.
   always_comb begin
      o_gnt = '0;
      o_idx = '0;
      for (int k = NREQ; k >= 1; k--) begin
         if (i_req[(int'(i_last) + k) % NREQ]) begin
            o_gnt = '0;
            o_gnt[(int'(i_last) + k) % NREQ] = 1'b1;
            o_idx = IDW'((int'(i_last) + k) % NREQ);
         end
      end
   end

endmodule

// File: rtl/bmu_issue_arbiter.sv
// -----------------------------------------------------------------------------
// bmu_issue_arbiter
// Shares one BMU between NREQ requesters with round-robin arbitration,
// one issue per cycle. The winning request is loaded into the BMU issue
// register; a tag pipe of depth BMU_LAT+1 follows the operation so its
// result can be returned with the originating requester id. A quiesce
// handshake stops new grants and reports when all in-flight work is done.
//   clk - clock, rising edge
//   rst - synchronous active-high reset
//   bus - bmu_issue_arbiter_if master: requester ports, BMU issue/result
//         bundle, response port, quiesce_req/ack, busy, dbg_state
// -----------------------------------------------------------------------------
module bmu_issue_arbiter
   import bmu_pkg::*;
#(
   parameter int NREQ    = 2,
   parameter int BMU_LAT = 1,
   parameter int W       = BMU_W
) (
   input  logic                  clk,
   input  logic                  rst,
   bmu_issue_arbiter_if.master   bus
);

   localparam int IDW = $clog2(NREQ);
   localparam int CW  = $clog2(BMU_LAT + 3);

   arb_state_e                r_state;
   arb_state_e                w_state_nxt;
   logic [IDW-1:0]            r_last;
   logic [BMU_LAT:0]          r_tag_v;
   logic [BMU_LAT:0][IDW-1:0] r_tag_id;
   logic [CW-1:0]             r_inflight;
   logic [CW-1:0]             w_cnt_nxt;
   logic                      r_busy;

   logic                      r_bmu_valid;
   logic [W-1:0]              r_bmu_a;
   logic [W-1:0]              r_bmu_b;
   bmu_ap_t                   r_bmu_ap;
   logic                      r_bmu_csr_ren;
   logic [W-1:0]              r_bmu_csr_rddata;

   logic                      r_rsp_valid;
   logic [IDW-1:0]            r_rsp_id;
   logic [W-1:0]              r_rsp_data;
   logic                      r_rsp_error;

   logic [NREQ-1:0]           w_gnt;
   logic [IDW-1:0]            w_idx;
   logic                      w_en;
   logic                      w_hs;

   bmu_rr_arbiter #(.NREQ(NREQ)) u_rr (
      .i_req  (bus.req_valid),
      .i_last (r_last),
      .o_gnt  (w_gnt),
      .o_idx  (w_idx)
   );

   // Grants only in RUN with no quiesce pending; the rst term keeps a
   // request presented during reset from being counted as a transfer.
   assign w_en          = !rst && (r_state == RUN) && !bus.quiesce_req;
   assign bus.req_ready = w_en ? w_gnt : '0;
   assign w_hs          = |bus.req_ready;

   // At most one issue and one response per cycle; both together cancel.
   assign w_cnt_nxt = r_inflight + CW'(w_hs) - CW'(r_rsp_valid);

   always_comb begin
      w_state_nxt = r_state;
      case (r_state)
         RUN:     if (bus.quiesce_req) w_state_nxt = DRAIN;
         DRAIN: begin
            if (!bus.quiesce_req)    w_state_nxt = RUN;
            else if (w_cnt_nxt == '0) w_state_nxt = HALT;
         end
         HALT:    if (!bus.quiesce_req) w_state_nxt = RUN;
         default: w_state_nxt = RUN;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         r_state    <= RUN;
         r_last     <= IDW'(NREQ - 1);
         r_inflight <= '0;
         r_busy     <= 1'b0;
      end else begin
         r_state    <= w_state_nxt;
         r_inflight <= w_cnt_nxt;
         r_busy     <= (w_cnt_nxt != '0);
         if (w_hs) r_last <= w_idx;
      end
   end

   // Issue register: operands hold when nothing is issued.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_bmu_valid      <= 1'b0;
         r_bmu_a          <= '0;
         r_bmu_b          <= '0;
         r_bmu_ap         <= '0;
         r_bmu_csr_ren    <= 1'b0;
         r_bmu_csr_rddata <= '0;
      end else begin
         r_bmu_valid <= w_hs;
         if (w_hs) begin
            r_bmu_a          <= bus.req_a[w_idx];
            r_bmu_b          <= bus.req_b[w_idx];
            r_bmu_ap         <= bus.req_ap[w_idx];
            r_bmu_csr_ren    <= bus.req_csr_ren[w_idx];
            r_bmu_csr_rddata <= bus.req_csr_rddata[w_idx];
         end
      end
   end

   // Stage k of the tag pipe is valid in the cycle issue+1+k, so stage
   // BMU_LAT lines up with bmu_result_ff for that operation.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_tag_v     <= '0;
         r_tag_id    <= '0;
         r_rsp_valid <= 1'b0;
         r_rsp_id    <= '0;
         r_rsp_data  <= '0;
         r_rsp_error <= 1'b0;
      end else begin
         r_tag_v     <= {r_tag_v[BMU_LAT-1:0], w_hs};
         r_tag_id    <= {r_tag_id[BMU_LAT-1:0], w_idx};
         r_rsp_valid <= r_tag_v[BMU_LAT];
         if (r_tag_v[BMU_LAT]) begin
            r_rsp_id    <= r_tag_id[BMU_LAT];
            r_rsp_data  <= bus.bmu_result_ff;
            r_rsp_error <= bus.bmu_error;
         end
      end
   end

   assign bus.bmu_valid_in      = r_bmu_valid;
   assign bus.bmu_a_in          = r_bmu_a;
   assign bus.bmu_b_in          = r_bmu_b;
   assign bus.bmu_ap            = r_bmu_ap;
   assign bus.bmu_csr_ren_in    = r_bmu_csr_ren;
   assign bus.bmu_csr_rddata_in = r_bmu_csr_rddata;
   assign bus.rsp_valid         = r_rsp_valid;
   assign bus.rsp_id            = r_rsp_id;
   assign bus.rsp_data          = r_rsp_data;
   assign bus.rsp_error         = r_rsp_error;
   assign bus.quiesce_ack       = (r_state == HALT);
   assign bus.busy              = r_busy;
   assign bus.dbg_state         = r_state;

endmodule
